// File: rtl/cache_controller_if.sv
// Memory-side bus of the cache controller: one word-beat request (read or write) completed by a one-cycle ack.
interface cache_controller_if #(
    parameter int ADDR_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_ack;

    modport master (output mem_read, output mem_write, output mem_address, input mem_ack);
    modport slave  (input mem_read, input mem_write, input mem_address, output mem_ack);
endinterface

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped write-back data cache: tag compare, dirty-victim write-back,
// word-by-word refill, then tag/valid/dirty update. Array lookup is combinational and lives outside.
module cache_controller #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int BYTE_W   = 2,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_address,
    output logic                busywait,
    input  logic                tag_hit,
    input  logic                victim_dirty,
    input  logic [TAG_W-1:0]    victim_tag,
    output logic [INDEX_W-1:0]  ctrl_index,
    output logic [TAG_W-1:0]    ctrl_tag,
    output logic [OFFSET_W-1:0] ctrl_offset,
    output logic                word_we,
    output logic                line_we,
    output logic                tag_we,
    output logic [OFFSET_W-1:0] beat,
    cache_controller_if.master  mem
);

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, UPDATE} state_t;

    state_t              state, state_d;
    logic [OFFSET_W-1:0] beat_d;
    logic                op_write;
    logic                latch_en;
    logic                busy;
    logic                last_beat;
    logic                unused_byte_bits;

    assign last_beat        = (beat == {OFFSET_W{1'b1}});
    assign unused_byte_bits = &{1'b0, cpu_address[BYTE_W-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat        <= '0;
            ctrl_tag    <= '0;
            ctrl_index  <= '0;
            ctrl_offset <= '0;
            op_write    <= 1'b0;
        end else begin
            beat <= beat_d;
            if (latch_en) begin
                ctrl_tag    <= cpu_address[ADDR_W-1 -: TAG_W];
                ctrl_index  <= cpu_address[BYTE_W+OFFSET_W +: INDEX_W];
                ctrl_offset <= cpu_address[BYTE_W +: OFFSET_W];
                op_write    <= cpu_write;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d         = state;
        beat_d          = beat;
        latch_en        = 1'b0;
        busy            = 1'b0;
        word_we         = 1'b0;
        line_we         = 1'b0;
        tag_we          = 1'b0;
        mem.mem_read    = 1'b0;
        mem.mem_write   = 1'b0;
        mem.mem_address = '0;

        case (state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    latch_en = 1'b1;
                    busy     = 1'b1;
                    state_d  = COMPARE;
                end
            end
            COMPARE: begin
                beat_d = '0;
                if (tag_hit) begin
                    word_we = op_write;
                    state_d = IDLE;
                end else begin
                    busy    = 1'b1;
                    state_d = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                busy            = 1'b1;
                mem.mem_write   = 1'b1;
                mem.mem_address = {victim_tag, ctrl_index, beat, {BYTE_W{1'b0}}};
                if (mem.mem_ack) begin
                    beat_d = beat + 1'b1;
                    if (last_beat) state_d = REFILL;
                end
            end
            REFILL: begin
                busy            = 1'b1;
                mem.mem_read    = 1'b1;
                mem.mem_address = {ctrl_tag, ctrl_index, beat, {BYTE_W{1'b0}}};
                line_we         = mem.mem_ack;
                if (mem.mem_ack) begin
                    beat_d = beat + 1'b1;
                    if (last_beat) state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                tag_we  = 1'b1;
                state_d = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A CPU request held across reset must not show as a stall while the controller is held in reset.
    assign busywait = busy & reset;

endmodule
